// File: rtl/req_rr_arbiter_pkg.sv
// Shared constants and state encoding for the round-robin grant arbiter.
package req_rr_arbiter_pkg;

   localparam int N     = 7;
   localparam int IDX_W = 3;
   localparam int CNT_W = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

endpackage

// File: rtl/req_rr_arbiter_if.sv
// Request/grant bundle between the requesters, the arbiter and the downstream consumer.
interface req_rr_arbiter_if;
   import req_rr_arbiter_pkg::*;

   logic [N-1:0]     req;
   logic             gnt_ready;
   logic             gnt_valid;
   logic [IDX_W-1:0] gnt_idx;
   logic [N-1:0]     gnt_onehot;
   logic [CNT_W-1:0] gnt_count;

   modport master (
      input  req, gnt_ready,
      output gnt_valid, gnt_idx, gnt_onehot, gnt_count
   );

   modport slave (
      output req, gnt_ready,
      input  gnt_valid, gnt_idx, gnt_onehot, gnt_count
   );

endinterface

// File: rtl/req_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping 6 -> 0.
module rr_pick
   import req_rr_arbiter_pkg::*;
(
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last,
   output logic             any,
   output logic [IDX_W-1:0] idx,
   output logic [N-1:0]     onehot
);

   int               cand;
   logic [IDX_W-1:0] candIdx;

   // Walk from the farthest candidate to the nearest so the closest set bit wins last.
   always_comb begin
      any     = 1'b0;
      idx     = '0;
      onehot  = '0;
      cand    = 0;
      candIdx = '0;
      for (int i = N; i >= 1; i--) begin
         cand    = (int'(last) + i) % N;
         candIdx = IDX_W'(cand);
         if (req[candIdx]) begin
            any    = 1'b1;
            idx    = candIdx;
            onehot = N'(1) << candIdx;
         end
      end
   end

endmodule

// File: rtl/req_rr_arbiter.sv
// Round-robin arbiter issuing one committed grant at a time under a valid/ready handshake.
module req_rr_arbiter
   import req_rr_arbiter_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   req_rr_arbiter_if.master bus
);

   state_t           state, nextState;
   logic [IDX_W-1:0] last, nextLast;
   logic             gntValid, nextValid;
   logic [IDX_W-1:0] gntIdx, nextIdx;
   logic [N-1:0]     gntOnehot, nextOnehot;
   logic [CNT_W-1:0] gntCount, nextCount;

   logic [IDX_W-1:0] pickLast;
   logic             pickAny;
   logic [IDX_W-1:0] pickIdx;
   logic [N-1:0]     pickOnehot;

   // On a handshake the accepted index becomes the pointer, so search from it directly.
   assign pickLast = (state == GRANT) ? gntIdx : last;

   rr_pick picker (
      .req    (bus.req),
      .last   (pickLast),
      .any    (pickAny),
      .idx    (pickIdx),
      .onehot (pickOnehot)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         last      <= IDX_W'(N - 1);
         gntValid  <= 1'b0;
         gntIdx    <= '0;
         gntOnehot <= '0;
         gntCount  <= '0;
      end else begin
         state     <= nextState;
         last      <= nextLast;
         gntValid  <= nextValid;
         gntIdx    <= nextIdx;
         gntOnehot <= nextOnehot;
         gntCount  <= nextCount;
      end
   end

   // A held grant ignores req until accepted; acceptance chains straight into the next pick.
   always_comb begin
      nextState  = state;
      nextLast   = last;
      nextValid  = gntValid;
      nextIdx    = gntIdx;
      nextOnehot = gntOnehot;
      nextCount  = gntCount;
      unique case (state)
         IDLE: begin
            nextValid  = 1'b0;
            nextOnehot = '0;
            if (pickAny) begin
               nextState  = GRANT;
               nextValid  = 1'b1;
               nextIdx    = pickIdx;
               nextOnehot = pickOnehot;
            end
         end
         GRANT: begin
            if (bus.gnt_ready) begin
               nextLast  = gntIdx;
               nextCount = gntCount + 1'b1;
               if (pickAny) begin
                  nextIdx    = pickIdx;
                  nextOnehot = pickOnehot;
               end else begin
                  nextState  = IDLE;
                  nextValid  = 1'b0;
                  nextOnehot = '0;
               end
            end
         end
         default: nextState = IDLE;
      endcase
   end

   assign bus.gnt_valid  = gntValid;
   assign bus.gnt_idx    = gntIdx;
   assign bus.gnt_onehot = gntOnehot;
   assign bus.gnt_count  = gntCount;

endmodule

// File: tb/tb_req_rr_arbiter.sv
// Directed scoreboard bench for req_rr_arbiter: stimulus queues expected handshakes, a monitor checks them.
module tb_req_rr_arbiter;

   typedef struct {
      logic [2:0] idx;
      logic [6:0] onehot;
      logic [7:0] count;
   } exp_t;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   exp_t expQ[$];

   req_rr_arbiter_if bus ();

   req_rr_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every accepted grant must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!reset && bus.gnt_valid && bus.gnt_ready) begin
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected handshake: got idx %0d count %0d, want none", bus.gnt_idx, bus.gnt_count);
         end else begin
            exp_t e;
            e = expQ.pop_front();
            if (bus.gnt_idx !== e.idx || bus.gnt_onehot !== e.onehot || bus.gnt_count !== e.count) begin
               errors++;
               $display("[TB] FAIL handshake: got idx %0d onehot %b count %0d, want idx %0d onehot %b count %0d",
                        bus.gnt_idx, bus.gnt_onehot, bus.gnt_count, e.idx, e.onehot, e.count);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [6:0] reqVal, input logic readyVal);
      bus.req       = reqVal;
      bus.gnt_ready = readyVal;
   endtask

   task automatic expectHandshake(input logic [2:0] idx, input logic [7:0] count);
      exp_t e;
      e.idx    = idx;
      e.onehot = 7'b0000001 << idx;
      e.count  = count;
      expQ.push_back(e);
   endtask

   task automatic checkOutput(input string name, input logic valid, input logic [2:0] idx,
                              input logic [6:0] onehot, input logic [7:0] count);
      @(negedge clk);
      checks++;
      if (bus.gnt_valid !== valid || bus.gnt_idx !== idx || bus.gnt_onehot !== onehot || bus.gnt_count !== count) begin
         errors++;
         $display("[TB] FAIL %s: got valid %b idx %0d onehot %b count %0d, want valid %b idx %0d onehot %b count %0d",
                  name, bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, bus.gnt_count, valid, idx, onehot, count);
      end
      tick();
   endtask

   task automatic checkDrained(input string name);
      @(negedge clk);
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL %s: got %0d handshakes still pending, want 0", name, expQ.size());
      end
      expQ.delete();
      tick();
   endtask

   task automatic resetDut();
      reset = 1'b1;
      applyStimulus(7'b0, 1'b0);
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      applyStimulus(7'b0, 1'b0);

      // All requesting with constant ready: strict rotation 0..6 then wrap.
      resetDut();
      checkOutput("reset state", 1'b0, 3'd0, 7'b0000000, 8'd0);
      applyStimulus(7'b1111111, 1'b1);
      for (int i = 0; i < 8; i++) expectHandshake(3'(i % 7), 8'(i));
      tick();
      repeat (8) tick();
      applyStimulus(7'b1111111, 1'b0);
      checkOutput("rotation after 8", 1'b1, 3'd1, 7'b0000010, 8'd8);
      checkDrained("rotation drained");

      // Held grant stays stable while not ready, then advances to the next requester.
      resetDut();
      applyStimulus(7'b0100100, 1'b0);
      tick();
      for (int i = 0; i < 5; i++) checkOutput("hold idx2", 1'b1, 3'd2, 7'b0000100, 8'd0);
      applyStimulus(7'b0100100, 1'b1);
      expectHandshake(3'd2, 8'd0);
      tick();
      applyStimulus(7'b0100100, 1'b0);
      checkOutput("next after hold", 1'b1, 3'd5, 7'b0100000, 8'd1);

      // Pointer wrap between requesters 6 and 0.
      applyStimulus(7'b1000000, 1'b1);
      expectHandshake(3'd5, 8'd1);
      tick();
      applyStimulus(7'b1000001, 1'b1);
      expectHandshake(3'd6, 8'd2);
      tick();
      expectHandshake(3'd0, 8'd3);
      tick();
      expectHandshake(3'd6, 8'd4);
      tick();
      applyStimulus(7'b0, 1'b0);
      checkOutput("wrap to 0", 1'b1, 3'd0, 7'b0000001, 8'd5);
      checkDrained("wrap drained");

      // Committed grant survives request withdrawal; ready while idle is ignored.
      resetDut();
      applyStimulus(7'b0001000, 1'b0);
      tick();
      applyStimulus(7'b0, 1'b0);
      checkOutput("committed 1", 1'b1, 3'd3, 7'b0001000, 8'd0);
      checkOutput("committed 2", 1'b1, 3'd3, 7'b0001000, 8'd0);
      applyStimulus(7'b0, 1'b1);
      expectHandshake(3'd3, 8'd0);
      tick();
      checkOutput("idle after accept", 1'b0, 3'd3, 7'b0000000, 8'd1);
      checkOutput("ready while idle", 1'b0, 3'd3, 7'b0000000, 8'd1);
      applyStimulus(7'b0, 1'b0);
      checkDrained("committed drained");

      // Reset wins over a simultaneous handshake and restores the pointer.
      resetDut();
      applyStimulus(7'b1111111, 1'b0);
      tick();
      applyStimulus(7'b1111111, 1'b1);
      expectHandshake(3'd0, 8'd0);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      applyStimulus(7'b0, 1'b0);
      checkOutput("mid-grant reset", 1'b0, 3'd0, 7'b0000000, 8'd0);
      applyStimulus(7'b1111111, 1'b0);
      tick();
      checkOutput("grant after reset", 1'b1, 3'd0, 7'b0000001, 8'd0);
      checkDrained("reset drained");

      // Lone requester regranted back-to-back; counter wraps after 256 accepts.
      resetDut();
      applyStimulus(7'b0000001, 1'b1);
      for (int i = 0; i < 256; i++) expectHandshake(3'd0, 8'(i));
      tick();
      repeat (256) tick();
      applyStimulus(7'b0000001, 1'b0);
      checkOutput("count wrap", 1'b1, 3'd0, 7'b0000001, 8'd0);
      checkDrained("count drained");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
